// File: rtl/sdram_arbiter.sv
// Round-robin arbiter sharing one SDRAM controller between the ADC writer (port 0)
// and host readout (port 1), with a per-transaction watchdog.
module sdram_arbiter #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        P0_Req,
    input  logic        P0_WnR,
    input  logic [21:0] P0_Address,
    input  logic [15:0] P0_WrData,
    input  logic        P1_Req,
    input  logic        P1_WnR,
    input  logic [21:0] P1_Address,
    input  logic [15:0] P1_WrData,
    output logic        P0_Gnt,
    output logic        P1_Gnt,
    output logic        P0_Done,
    output logic        P1_Done,
    output logic        P0_Err,
    output logic        P1_Err,
    output logic [15:0] RdData,
    output logic        Arb_Busy,
    output logic        Mem_Req,
    output logic        Mem_WnR,
    output logic [21:0] Mem_Address,
    output logic [15:0] Mem_WrData,
    output logic        Mem_DataOe,
    input  logic [15:0] Mem_RdData,
    input  logic        Mem_Ack,
    input  logic        Mem_Busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

    state_t     state;
    logic       gnt_port;
    logic       last;
    logic       sel_port;
    logic [7:0] watchdog;
    logic       wd_expired;

    // On a tie the port that was not served last wins.
    always_comb begin
        sel_port = 1'b0;
        if (P0_Req && P1_Req) begin
            sel_port = ~last;
        end else if (P1_Req) begin
            sel_port = 1'b1;
        end
    end

    assign wd_expired = (watchdog == TIMEOUT_CNT);
    assign Mem_Req    = (state == ISSUE);
    assign Arb_Busy   = (state != IDLE);
    assign Mem_DataOe = Mem_WnR && ((state == ISSUE) || (state == WAIT));

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state       <= IDLE;
            gnt_port    <= 1'b0;
            last        <= 1'b1;
            watchdog    <= '0;
            P0_Gnt      <= 1'b0;
            P1_Gnt      <= 1'b0;
            P0_Done     <= 1'b0;
            P1_Done     <= 1'b0;
            P0_Err      <= 1'b0;
            P1_Err      <= 1'b0;
            RdData      <= '0;
            Mem_WnR     <= 1'b0;
            Mem_Address <= '0;
            Mem_WrData  <= '0;
        end else begin
            P0_Done <= 1'b0;
            P1_Done <= 1'b0;
            P0_Err  <= 1'b0;
            P1_Err  <= 1'b0;
            case (state)
                IDLE: begin
                    if (P0_Req || P1_Req) begin
                        gnt_port    <= sel_port;
                        Mem_WnR     <= sel_port ? P1_WnR     : P0_WnR;
                        Mem_Address <= sel_port ? P1_Address : P0_Address;
                        Mem_WrData  <= sel_port ? P1_WrData  : P0_WrData;
                        P0_Gnt      <= ~sel_port;
                        P1_Gnt      <= sel_port;
                        watchdog    <= '0;
                        state       <= ISSUE;
                    end
                end
                ISSUE: begin
                    watchdog <= watchdog + 8'd1;
                    if (wd_expired) begin
                        P0_Done <= ~gnt_port;
                        P1_Done <= gnt_port;
                        P0_Err  <= ~gnt_port;
                        P1_Err  <= gnt_port;
                        state   <= DONE;
                    end else if (Mem_Ack) begin
                        state <= WAIT;
                    end
                end
                WAIT: begin
                    watchdog <= watchdog + 8'd1;
                    if (wd_expired) begin
                        P0_Done <= ~gnt_port;
                        P1_Done <= gnt_port;
                        P0_Err  <= ~gnt_port;
                        P1_Err  <= gnt_port;
                        state   <= DONE;
                    end else if (!Mem_Busy) begin
                        if (!Mem_WnR) begin
                            RdData <= Mem_RdData;
                        end
                        P0_Done <= ~gnt_port;
                        P1_Done <= gnt_port;
                        state   <= DONE;
                    end
                end
                DONE: begin
                    last   <= gnt_port;
                    P0_Gnt <= 1'b0;
                    P1_Gnt <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

endmodule
